// File: rtl/gpio_pkg.sv
// gpio_pkg: register map constants shared by the GPIO bank.
// Offsets select a register inside one channel's 16-byte window.
package gpio_pkg;

    localparam logic [1:0] OFF_DATA_OUT    = 2'd0;
    localparam logic [1:0] OFF_DATA_IN     = 2'd1;
    localparam logic [1:0] OFF_EDGE_MASK   = 2'd2;
    localparam logic [1:0] OFF_EDGE_STATUS = 2'd3;

    localparam int CH_STRIDE = 16;

endpackage

// File: rtl/gpio_channel.sv
// gpio_channel: one GPIO channel with synchroniser, rising-edge
// capture, four registers and a local combinational read mux.
module gpio_channel
    import gpio_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en_i,
    input  logic [1:0]       off_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic [WIDTH-1:0] pin_i,
    output logic [WIDTH-1:0] gpio_o,
    output logic [WIDTH-1:0] rd_data_o,
    output logic             irq_o
);

    logic [WIDTH-1:0] out_q, out_d;
    logic [WIDTH-1:0] mask_q, mask_d;
    logic [WIDTH-1:0] status_q, status_d;
    logic [WIDTH-1:0] sync1_q, sync1_d;
    logic [WIDTH-1:0] sync2_q, sync2_d;
    logic [WIDTH-1:0] prev_q, prev_d;
    logic [WIDTH-1:0] edge_det;
    logic [WIDTH-1:0] clr;

    // Next state: pin pipeline, register writes, sticky edge capture (set beats clear).
    always_comb begin
        out_d    = out_q;
        mask_d   = mask_q;
        sync1_d  = pin_i;
        sync2_d  = sync1_q;
        prev_d   = sync2_q;
        edge_det = sync2_q & ~prev_q & mask_q;
        clr      = '0;
        if (wr_en_i && off_i == OFF_DATA_OUT) begin
            out_d = wr_data_i;
        end
        if (wr_en_i && off_i == OFF_EDGE_MASK) begin
            mask_d = wr_data_i;
        end
        if (wr_en_i && off_i == OFF_EDGE_STATUS) begin
            clr = wr_data_i;
        end
        status_d = (status_q & ~clr) | edge_det;
    end

    // State registers, all cleared by the asynchronous reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_q    <= '0;
            mask_q   <= '0;
            status_q <= '0;
            sync1_q  <= '0;
            sync2_q  <= '0;
            prev_q   <= '0;
        end else begin
            out_q    <= out_d;
            mask_q   <= mask_d;
            status_q <= status_d;
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            prev_q   <= prev_d;
        end
    end

    // Local read mux over the current (pre-write) register values.
    always_comb begin
        rd_data_o = '0;
        unique case (off_i)
            OFF_DATA_OUT:    rd_data_o = out_q;
            OFF_DATA_IN:     rd_data_o = sync2_q;
            OFF_EDGE_MASK:   rd_data_o = mask_q;
            OFF_EDGE_STATUS: rd_data_o = status_q;
            default:         rd_data_o = '0;
        endcase
    end

    assign gpio_o = out_q;
    assign irq_o  = |status_q;

endmodule

// File: rtl/gpio_mmio_bank.sv
// gpio_mmio_bank: N_CH memory-mapped GPIO channels with a
// registered read port and a combined edge interrupt.
module gpio_mmio_bank
    import gpio_pkg::*;
#(
    parameter int N_CH   = 2,
    parameter int WIDTH  = 8,
    parameter int ADDR_W = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_W-1:0]     addr_i,
    input  logic                  wr_en_i,
    input  logic [31:0]           wr_data_i,
    input  logic                  rd_en_i,
    output logic [31:0]           rd_data_o,
    output logic                  rd_valid_o,
    input  logic [N_CH*WIDTH-1:0] gpio_i,
    output logic [N_CH*WIDTH-1:0] gpio_o,
    output logic                  irq_o
);

    localparam int CH_LSB = $clog2(CH_STRIDE);
    localparam int CH_W   = ADDR_W - CH_LSB;

    logic [CH_W-1:0]  ch_idx;
    logic [1:0]       off;
    logic [WIDTH-1:0] ch_rd [N_CH];
    logic [N_CH-1:0]  ch_irq;
    logic [N_CH-1:0]  ch_wr;
    logic [WIDTH-1:0] sel_rd;
    logic             mapped;
    logic [31:0]      rd_data_q, rd_data_d;
    logic             rd_valid_q, rd_valid_d;
    logic             unused_bits;

    assign ch_idx      = addr_i[ADDR_W-1:CH_LSB];
    assign off         = addr_i[3:2];
    assign unused_bits = ^{addr_i[1:0], wr_data_i};

    // Channel decode: route the write strobe and pick the read source.
    always_comb begin
        mapped = 1'b0;
        ch_wr  = '0;
        sel_rd = '0;
        for (int c = 0; c < N_CH; c++) begin
            if (ch_idx == CH_W'(c)) begin
                mapped   = 1'b1;
                ch_wr[c] = wr_en_i;
                sel_rd   = ch_rd[c];
            end
        end
    end

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        gpio_channel #(
            .WIDTH(WIDTH)
        ) u_ch (
            .clk      (clk),
            .reset    (reset),
            .wr_en_i  (ch_wr[g]),
            .off_i    (off),
            .wr_data_i(wr_data_i[WIDTH-1:0]),
            .pin_i    (gpio_i[g*WIDTH +: WIDTH]),
            .gpio_o   (gpio_o[g*WIDTH +: WIDTH]),
            .rd_data_o(ch_rd[g]),
            .irq_o    (ch_irq[g])
        );
    end

    // Read response: zero-extended data, zero for unmapped channels.
    always_comb begin
        rd_data_d  = '0;
        rd_valid_d = rd_en_i;
        if (rd_en_i && mapped) begin
            rd_data_d[WIDTH-1:0] = sel_rd;
        end
    end

    // Registered read port; reset kills any pending response.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    assign rd_data_o  = rd_data_q;
    assign rd_valid_o = rd_valid_q;
    assign irq_o      = |ch_irq;

endmodule

// File: tb/tb_gpio_mmio_bank.sv
// tb_gpio_mmio_bank: directed scenarios for the GPIO bank,
// N_CH=2, WIDTH=8, ADDR_W=8.
module tb_gpio_mmio_bank;

    logic        clk;
    logic        reset;
    logic [7:0]  addr_i;
    logic        wr_en_i;
    logic [31:0] wr_data_i;
    logic        rd_en_i;
    logic [31:0] rd_data_o;
    logic        rd_valid_o;
    logic [15:0] gpio_i;
    logic [15:0] gpio_o;
    logic        irq_o;

    int vectors = 0;
    int errors  = 0;

    gpio_mmio_bank #(
        .N_CH  (2),
        .WIDTH (8),
        .ADDR_W(8)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .addr_i    (addr_i),
        .wr_en_i   (wr_en_i),
        .wr_data_i (wr_data_i),
        .rd_en_i   (rd_en_i),
        .rd_data_o (rd_data_o),
        .rd_valid_o(rd_valid_o),
        .gpio_i    (gpio_i),
        .gpio_o    (gpio_o),
        .irq_o     (irq_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic wr(input logic [7:0] a, input logic [31:0] d);
        @(negedge clk);
        addr_i    = a;
        wr_data_i = d;
        wr_en_i   = 1'b1;
        @(negedge clk);
        wr_en_i   = 1'b0;
    endtask

    task automatic rd(input logic [7:0] a, output logic [31:0] d,
                      output logic v);
        @(negedge clk);
        addr_i  = a;
        rd_en_i = 1'b1;
        @(negedge clk);
        rd_en_i = 1'b0;
        d = rd_data_o;
        v = rd_valid_o;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        logic        v;
        reset     = 1'b0;
        addr_i    = '0;
        wr_en_i   = 1'b0;
        wr_data_i = '0;
        rd_en_i   = 1'b0;
        gpio_i    = '0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        vectors++;
        if (gpio_o !== 16'h0000) begin
            errors++;
            $display("FAIL reset_gpio_o: got %h want 0000", gpio_o);
        end
        vectors++;
        if (irq_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_irq: got %b want 0", irq_o);
        end
        vectors++;
        if (rd_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_rd_valid: got %b want 0", rd_valid_o);
        end
        for (int a = 0; a < 8; a++) begin
            logic [7:0] ad;
            ad = 8'((a / 4) * 16 + (a % 4) * 4);
            rd(ad, d, v);
            vectors++;
            if (d !== 32'h0 || v !== 1'b1) begin
                errors++;
                $display("FAIL reset_read[%h]: got %h/%b want 00000000/1",
                         ad, d, v);
            end
        end
    endtask

    task automatic test_output();
        logic [31:0] d;
        logic        v;
        wr(8'h10, 32'h000000A5);
        vectors++;
        if (gpio_o !== 16'hA500) begin
            errors++;
            $display("FAIL out_gpio_o: got %h want a500", gpio_o);
        end
        rd(8'h10, d, v);
        vectors++;
        if (d !== 32'h000000A5 || v !== 1'b1) begin
            errors++;
            $display("FAIL out_read: got %h/%b want 000000a5/1", d, v);
        end
        @(negedge clk);
        vectors++;
        if (rd_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL out_valid_drop: got %b want 0", rd_valid_o);
        end
    endtask

    task automatic test_rw_same();
        logic [31:0] d;
        @(negedge clk);
        addr_i    = 8'h10;
        wr_data_i = 32'h0000003C;
        wr_en_i   = 1'b1;
        rd_en_i   = 1'b1;
        @(negedge clk);
        wr_en_i = 1'b0;
        rd_en_i = 1'b0;
        d = rd_data_o;
        vectors++;
        if (d !== 32'h000000A5) begin
            errors++;
            $display("FAIL rw_same_read: got %h want 000000a5", d);
        end
        vectors++;
        if (gpio_o !== 16'h3C00) begin
            errors++;
            $display("FAIL rw_same_gpio_o: got %h want 3c00", gpio_o);
        end
    endtask

    task automatic test_input_latency();
        logic [31:0] d;
        logic        v;
        wr(8'h08, 32'h08);
        gpio_i[3] = 1'b1;
        addr_i    = 8'h04;
        rd_en_i   = 1'b1;
        @(negedge clk);
        vectors++;
        if (irq_o !== 1'b0 || rd_data_o !== 32'h0) begin
            errors++;
            $display("FAIL lat_k: got irq=%b din=%h want 0/00000000",
                     irq_o, rd_data_o);
        end
        @(negedge clk);
        vectors++;
        if (irq_o !== 1'b0 || rd_data_o !== 32'h0) begin
            errors++;
            $display("FAIL lat_k1: got irq=%b din=%h want 0/00000000",
                     irq_o, rd_data_o);
        end
        @(negedge clk);
        rd_en_i = 1'b0;
        vectors++;
        if (irq_o !== 1'b1 || rd_data_o !== 32'h08 || rd_valid_o !== 1'b1) begin
            errors++;
            $display("FAIL lat_k2: got irq=%b din=%h v=%b want 1/00000008/1",
                     irq_o, rd_data_o, rd_valid_o);
        end
        rd(8'h0C, d, v);
        vectors++;
        if (d !== 32'h08) begin
            errors++;
            $display("FAIL lat_status: got %h want 00000008", d);
        end
        gpio_i[3] = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_w1c_race();
        logic [31:0] d;
        logic        v;
        @(negedge clk);
        gpio_i[3] = 1'b1;
        @(negedge clk);
        @(negedge clk);
        addr_i    = 8'h0C;
        wr_data_i = 32'h08;
        wr_en_i   = 1'b1;
        @(negedge clk);
        wr_en_i = 1'b0;
        vectors++;
        if (irq_o !== 1'b1) begin
            errors++;
            $display("FAIL race_irq: got %b want 1", irq_o);
        end
        rd(8'h0C, d, v);
        vectors++;
        if (d !== 32'h08) begin
            errors++;
            $display("FAIL race_status: got %h want 00000008", d);
        end
        gpio_i[3] = 1'b0;
        repeat (3) @(negedge clk);
        wr(8'h0C, 32'h08);
        vectors++;
        if (irq_o !== 1'b0) begin
            errors++;
            $display("FAIL clear_irq: got %b want 0", irq_o);
        end
        rd(8'h0C, d, v);
        vectors++;
        if (d !== 32'h0) begin
            errors++;
            $display("FAIL clear_status: got %h want 00000000", d);
        end
    endtask

    task automatic test_mask_unmapped();
        logic [31:0] d;
        logic        v;
        gpio_i[0] = 1'b1;
        repeat (4) @(negedge clk);
        rd(8'h0C, d, v);
        vectors++;
        if (d !== 32'h0 || irq_o !== 1'b0) begin
            errors++;
            $display("FAIL mask_off: got %h irq=%b want 00000000/0", d, irq_o);
        end
        wr(8'h08, 32'h09);
        repeat (2) @(negedge clk);
        rd(8'h0C, d, v);
        vectors++;
        if (d !== 32'h0) begin
            errors++;
            $display("FAIL mask_late: got %h want 00000000", d);
        end
        gpio_i[3] = 1'b1;
        repeat (4) @(negedge clk);
        wr(8'h08, 32'h00);
        rd(8'h0C, d, v);
        vectors++;
        if (d !== 32'h08 || irq_o !== 1'b1) begin
            errors++;
            $display("FAIL mask_clr_keep: got %h irq=%b want 00000008/1",
                     d, irq_o);
        end
        wr(8'h0C, 32'hFF);
        gpio_i = '0;
        repeat (3) @(negedge clk);
        wr(8'h20, 32'hFF);
        wr(8'h28, 32'hFF);
        vectors++;
        if (gpio_o !== 16'h3C00 || irq_o !== 1'b0) begin
            errors++;
            $display("FAIL unmapped_wr: got %h irq=%b want 3c00/0",
                     gpio_o, irq_o);
        end
        rd(8'h08, d, v);
        vectors++;
        if (d !== 32'h0) begin
            errors++;
            $display("FAIL unmapped_alias: got %h want 00000000", d);
        end
        rd(8'h20, d, v);
        vectors++;
        if (d !== 32'h0 || v !== 1'b1) begin
            errors++;
            $display("FAIL unmapped_rd: got %h/%b want 00000000/1", d, v);
        end
    endtask

    task automatic test_async_reset();
        wr(8'h08, 32'h08);
        gpio_i[3] = 1'b1;
        repeat (4) @(negedge clk);
        vectors++;
        if (irq_o !== 1'b1) begin
            errors++;
            $display("FAIL arst_setup_irq: got %b want 1", irq_o);
        end
        addr_i  = 8'h10;
        rd_en_i = 1'b1;
        #2;
        reset = 1'b0;
        #1;
        vectors++;
        if (gpio_o !== 16'h0 || irq_o !== 1'b0 || rd_valid_o !== 1'b0 ||
            rd_data_o !== 32'h0) begin
            errors++;
            $display("FAIL arst_now: got gpio=%h irq=%b v=%b d=%h want all 0",
                     gpio_o, irq_o, rd_valid_o, rd_data_o);
        end
        @(negedge clk);
        rd_en_i = 1'b0;
        vectors++;
        if (rd_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL arst_valid: got %b want 0", rd_valid_o);
        end
        gpio_i = '0;
        reset  = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_output();
        test_rw_same();
        test_input_latency();
        test_w1c_race();
        test_mask_unmapped();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/gpio_mmio_bank.md
# gpio_mmio_bank

Memory-mapped, multi-channel GPIO bank that replaces the fixed 8-bit zero-extended input and 8-bit ALU-driven output of the multicycle MIPS datapath. It sits on the datapath's load/store path, beside the memory system, and is selected by address decode upstream. Each channel adds three features: a registered output port, a two-flop-synchronised input port, and maskable rising-edge capture. Captured edges are combined into a single interrupt line.

## Interface
Parameters:
- N_CH, 2: number of GPIO channels, 1..8.
- WIDTH, 8: bits per channel, 1..32.
- ADDR_W, 8: byte-address width; must be ≥ 4 + clog2(N_CH).

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- addr_i  in  ADDR_W  byte address; [1:0] ignored, [3:2] register select, [ADDR_W-1:4] channel index.
- wr_en_i  in  1  write strobe, one cycle per write.
- wr_data_i  in  32  write data; only [WIDTH-1:0] used.
- rd_en_i  in  1  read strobe, one cycle per read.
- rd_data_o  out  32  read data, zero-extended from WIDTH; reset 0.
- rd_valid_o  out  1  high for one cycle when rd_data_o is valid; reset 0.
- gpio_i  in  N_CH*WIDTH  asynchronous pins; channel c occupies [c*WIDTH +: WIDTH].
- gpio_o  out  N_CH*WIDTH  registered output pins; reset 0.
- irq_o  out  1  OR of all EDGE_STATUS bits; reset 0.

## Operation
Per-channel registers, selected by offset addr_i[3:2]:
- 0 DATA_OUT: read/write; drives gpio_o.
- 1 DATA_IN: read-only; synchronised pin value. Writes are ignored.
- 2 EDGE_MASK: read/write; a 1 enables edge capture for that bit.
- 3 EDGE_STATUS: read / write-1-to-clear; holds a sticky 1 per captured rising edge.

Rules:
- Input path per bit: sync1 ← pin, sync2 ← sync1, prev ← sync2. DATA_IN = sync2.
- Edge detect: edge = sync2 & ~prev & EDGE_MASK. A masked-off edge is lost; it is not captured retroactively.
- EDGE_STATUS next value = (status & ~(wr_en_i && hit ? wr_data : 0)) | edge.
  - If a new edge and a W1C hit the same bit in the same cycle, the set wins and the bit stays 1.
- Clearing EDGE_MASK does not clear EDGE_STATUS.
- A channel index ≥ N_CH is unmapped: writes have no effect and reads return 0 with rd_valid_o still pulsing.
- wr_en_i and rd_en_i asserted together on the same address: the read returns the pre-write value.
- All flops reset to 0, including sync1, sync2 and prev.
  - A pin held high through reset release therefore produces one rising edge two cycles after release. Because EDGE_MASK resets to 0, this edge does not set status.
- Reset asserted mid-operation clears every register immediately, including any pending rd_valid_o. It is asynchronous and does not wait for the clock.

## Timing
- Write: DATA_OUT and gpio_o update at the clk edge where wr_en_i is sampled high.
- Read: rd_data_o and rd_valid_o are registered, with 1-cycle latency after rd_en_i.
  - Back-to-back reads every cycle are supported.
  - There is no backpressure.
- Input latency: a pin change captured into sync1 at edge k gives:
  - DATA_IN updated at edge k+1;
  - EDGE_STATUS set at edge k+2;
  - irq_o high after edge k+2. irq_o is taken from the status registers only, with no added combinational path from the pins.
- irq_o falls in the cycle after the W1C write that clears the last set status bit, provided no new edge arrives in that same cycle.

## Structure
- Package gpio_pkg holds:
  - the register offset constants (OFF_DATA_OUT = 2'd0, OFF_DATA_IN = 2'd1, OFF_EDGE_MASK = 2'd2, OFF_EDGE_STATUS = 2'd3);
  - CH_STRIDE = 16.
- Sub-module gpio_channel, parametrised by WIDTH, contains one channel's:
  - synchroniser;
  - edge detector;
  - the four registers;
  - a local read mux.
- The top level instantiates N_CH copies and provides:
  - channel/offset decode;
  - the registered read mux;
  - the irq OR-reduction.

## Test plan
- Reset, N_CH=2, WIDTH=8: hold reset low for 3 cycles. Then gpio_o=0, irq_o=0 and rd_valid_o=0, and a read of every offset returns 0.
- Output: write 0xA5 to addr 0x10 (channel 1 DATA_OUT). gpio_o[15:8]=0xA5 on the same edge; reading 0x10 returns 0x000000A5 one cycle later with rd_valid_o=1.
- Input latency: pulse gpio_i[3] high with EDGE_MASK(ch0)=0x08. DATA_IN(ch0)=0x08 one edge after capture, then EDGE_STATUS=0x08 and irq_o=1 one edge later.
- W1C race: in the same cycle, write 0x08 to 0x0C (ch0 EDGE_STATUS) while a new edge arrives on bit 3. Status stays 0x08 and irq_o stays 1. A second clear with no edge gives status 0 and irq_o=0.
- Masking and unmapped access:
  - An edge on bit 0 with mask 0 leaves status 0.
  - Setting the mask afterwards still leaves status 0.
  - A write to 0x20 (channel 2, unmapped) changes nothing.
  - A read of 0x20 returns 0 with rd_valid_o=1.
- Async reset mid-operation: assert reset between rd_en_i and rd_valid_o. rd_valid_o never pulses and all outputs are 0 before the next clock edge.
